emmc_traffic_gen: RTL and testbench



---
 rtl/emmc_traffic_gen_pkg.sv | 26 ++
 rtl/emmc_traffic_gen_if.sv | 36 +++
 rtl/emmc_traffic_gen_pattern.sv | 59 +++++
 rtl/emmc_traffic_gen.sv | 159 +++++++++++++++
 tb/tb_emmc_traffic_gen.sv | 394 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/emmc_traffic_gen_pkg.sv
// Shared types and constants for the eMMC write/read-back traffic generator.
// Optional halt-on-first-mismatch is enabled by EMMC_TG_STOP_ON_ERR_EN.
package emmc_tg_p;

    localparam int unsigned BLK_BYTES = 512;

    // x^8 + x^6 + x^5 + x^4 + 1 on a left-shifting register
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_INIT,
        WRITE,
        READ,
        ADVANCE,
        HALT
    } state_t;

    typedef enum logic [1:0] {
        CHECKER,
        WALK1,
        COUNT,
        LFSR
    } pattern_t;

endpackage

// File: rtl/emmc_traffic_gen_if.sv
// Host-side bundle between the traffic generator and the emmc_sm host.
// master = traffic generator, slave = emmc_sm.
interface emmc_traffic_gen_if;

    logic        host_start_o;
    logic        host_we_o;
    logic [15:0] host_blk_idx_o;
    logic [7:0]  host_blk_cnt_o;
    logic [7:0]  host_wr_dat_o;
    logic [7:0]  host_rd_dat_i;
    logic        host_dvalid_i;
    logic        host_ready_i;

    modport master (
        output host_start_o,
        output host_we_o,
        output host_blk_idx_o,
        output host_blk_cnt_o,
        output host_wr_dat_o,
        input  host_rd_dat_i,
        input  host_dvalid_i,
        input  host_ready_i
    );

    modport slave (
        input  host_start_o,
        input  host_we_o,
        input  host_blk_idx_o,
        input  host_blk_cnt_o,
        input  host_wr_dat_o,
        output host_rd_dat_i,
        output host_dvalid_i,
        output host_ready_i
    );

endinterface

// File: rtl/emmc_traffic_gen_pattern.sv
// Byte counter plus pattern generator, shared by write generation and
// read-back regeneration; last = every byte of the transfer was stepped.
module emmc_tg_pattern
    import emmc_tg_p::*;
#(
    parameter int unsigned BLK_CNT = 2
) (
    input  logic       clk_core,
    input  logic       rst_tk,
    input  pattern_t   pattern,
    input  logic [7:0] seed,
    input  logic       clr,
    input  logic       step,
    output logic [7:0] dat,
    output logic       last
);

    localparam int unsigned TOTAL = BLK_BYTES * BLK_CNT;
    localparam int unsigned N_W   = $clog2(TOTAL);
    localparam logic [N_W-1:0] N_LAST = N_W'(TOTAL - 1);

    logic [N_W-1:0] n_q;
    logic [7:0]     lfsr_q;
    logic           done_q;

    // The final byte holds once consumed so extra strobes see the same data
    always_ff @(posedge clk_core or posedge rst_tk) begin
        if (rst_tk) begin
            n_q    <= '0;
            lfsr_q <= 8'h01;
            done_q <= 1'b0;
        end else if (clr) begin
            n_q    <= '0;
            lfsr_q <= seed | 8'h01;
            done_q <= 1'b0;
        end else if (step && !done_q) begin
            if (n_q == N_LAST) begin
                done_q <= 1'b1;
            end else begin
                n_q    <= n_q + 1'b1;
                lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
            end
        end
    end

    always_comb begin
        dat = 8'h00;
        unique case (pattern)
            CHECKER: dat = n_q[0] ? 8'hAA : 8'h55;
            WALK1:   dat = 8'h01 << n_q[2:0];
            COUNT:   dat = n_q[7:0];
            LFSR:    dat = lfsr_q;
            default: dat = 8'h00;
        endcase
    end

    assign last = done_q;

endmodule

// File: rtl/emmc_traffic_gen.sv
// Write/read-back/compare traffic generator for the emmc_sm host.
// Define EMMC_TG_STOP_ON_ERR_EN to halt on the first read mismatch.
module emmc_traffic_gen
    import emmc_tg_p::*;
#(
    parameter int unsigned BLK_CNT    = 2,
    parameter int unsigned IDX_STRIDE = 2,
    parameter int unsigned IDX_LIMIT  = 1024,
    parameter int unsigned ERR_W      = 16
) (
    input  logic               clk_core,
    input  logic               rst_tk,
    input  logic               start_i,
    emmc_traffic_gen_if.master host,
    output logic               busy_o,
    output logic [1:0]         pattern_o,
    output logic [15:0]        pass_cnt_o,
    output logic [ERR_W-1:0]   err_cnt_o,
    output logic [15:0]        first_err_idx_o
);

    state_t      state_q;
    pattern_t    pat_q;
    logic        start_q;
    logic        we_q;
    logic        busy_q;
    logic [15:0] idx_q;
    logic [15:0] idx_nxt;
    logic [16:0] idx_sum;
    logic [15:0] pass_q;

    logic [7:0]  pat_dat;
    logic [7:0]  pat_seed;
    logic        pat_last;
    logic        pat_clr;
    logic        pat_step;

    logic        mis_q;
    logic [15:0] mis_idx_q;
    logic [ERR_W-1:0] err_q;
    logic [15:0] first_q;

    assign idx_sum = {1'b0, idx_q} + 17'(IDX_STRIDE);
    assign idx_nxt = (32'(idx_sum) >= IDX_LIMIT) ? '0 : idx_sum[15:0];

    assign pat_step = host.host_dvalid_i
                    && (state_q == WRITE || state_q == READ);

    // Rewind for read-back, and reseed with the next index on ADVANCE
    assign pat_clr  = (state_q == WRITE && host.host_ready_i)
                    || state_q == ADVANCE;
    assign pat_seed = (state_q == ADVANCE) ? idx_nxt[7:0] : idx_q[7:0];

    emmc_tg_pattern #(
        .BLK_CNT (BLK_CNT)
    ) u_pattern (
        .clk_core (clk_core),
        .rst_tk   (rst_tk),
        .pattern  (pat_q),
        .seed     (pat_seed),
        .clr      (pat_clr),
        .step     (pat_step),
        .dat      (pat_dat),
        .last     (pat_last)
    );

    always_ff @(posedge clk_core or posedge rst_tk) begin
        if (rst_tk) begin
            mis_q     <= 1'b0;
            mis_idx_q <= '0;
            err_q     <= '0;
            first_q   <= '0;
        end else begin
            mis_q     <= state_q == READ && host.host_dvalid_i
                      && !pat_last && (host.host_rd_dat_i != pat_dat);
            mis_idx_q <= idx_q;
            if (mis_q && err_q != '1)
                err_q <= err_q + 1'b1;
            if (mis_q && err_q == '0)
                first_q <= mis_idx_q;
        end
    end

    always_ff @(posedge clk_core or posedge rst_tk) begin
        if (rst_tk) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            idx_q   <= '0;
            pat_q   <= CHECKER;
            pass_q  <= '0;
        end else begin
`ifdef EMMC_TG_STOP_ON_ERR_EN
            if (mis_q && state_q != HALT) begin
                state_q <= HALT;
                start_q <= 1'b0;
                we_q    <= 1'b0;
                busy_q  <= 1'b1;
            end else
`endif
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= WAIT_INIT;
                        busy_q  <= 1'b1;
                    end
                end
                WAIT_INIT: begin
                    if (host.host_ready_i) begin
                        state_q <= WRITE;
                        start_q <= 1'b1;
                        we_q    <= 1'b1;
                    end
                end
                WRITE: begin
                    if (host.host_ready_i) begin
                        state_q <= READ;
                        we_q    <= 1'b0;
                    end
                end
                READ: begin
                    if (host.host_ready_i) begin
                        state_q <= ADVANCE;
                        start_q <= 1'b0;
                    end
                end
                ADVANCE: begin
                    pass_q <= pass_q + 16'd1;
                    idx_q  <= idx_nxt;
                    pat_q  <= pattern_t'(pat_q + 2'd1);
                    if (start_i) begin
                        state_q <= WRITE;
                        start_q <= 1'b1;
                        we_q    <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                HALT: state_q <= HALT;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign host.host_start_o   = start_q;
    assign host.host_we_o      = we_q;
    assign host.host_blk_idx_o = idx_q;
    assign host.host_blk_cnt_o = 8'(BLK_CNT);
    assign host.host_wr_dat_o  = pat_dat;

    assign busy_o          = busy_q;
    assign pattern_o       = pat_q;
    assign pass_cnt_o      = pass_q;
    assign err_cnt_o       = err_q;
    assign first_err_idx_o = first_q;

endmodule

// File: tb/tb_emmc_traffic_gen.sv
// Self-checking bench for emmc_traffic_gen with an echoing emmc_sm model.
// Expectations follow EMMC_TG_STOP_ON_ERR_EN when it is defined.
module tb_emmc_traffic_gen;

    localparam int BLK    = 2;
    localparam int STRIDE = 2;
    localparam int LIMIT  = 4;
    localparam int TOTAL  = 512 * BLK;

    logic        clk_core = 1'b0;
    logic        rst_tk;
    logic        start_i;
    logic        busy_o;
    logic [1:0]  pattern_o;
    logic [15:0] pass_cnt_o;
    logic [15:0] err_cnt_o;
    logic [15:0] first_err_idx_o;

    emmc_traffic_gen_if host ();

    emmc_traffic_gen #(
        .BLK_CNT    (BLK),
        .IDX_STRIDE (STRIDE),
        .IDX_LIMIT  (LIMIT),
        .ERR_W      (16)
    ) dut (
        .clk_core        (clk_core),
        .rst_tk          (rst_tk),
        .start_i         (start_i),
        .host            (host),
        .busy_o          (busy_o),
        .pattern_o       (pattern_o),
        .pass_cnt_o      (pass_cnt_o),
        .err_cnt_o       (err_cnt_o),
        .first_err_idx_o (first_err_idx_o)
    );

    always #5 clk_core = ~clk_core;

    int n_chk  = 0;
    int n_fail = 0;

    int m_idx, m_pat, m_pass, m_err, m_first;
    logic [7:0] exp_b  [TOTAL];
    logic [7:0] echo_b [TOTAL];

    // Expected byte stream of one transfer, straight from the pattern rules
    task automatic gen_exp(input int pat, input int idx);
        int l;
        l = (idx & 255) | 1;
        for (int n = 0; n < TOTAL; n++) begin
            case (pat)
                0: exp_b[n] = (n % 2 == 1) ? 8'hAA : 8'h55;
                1: exp_b[n] = 8'(1 << (n % 8));
                2: exp_b[n] = 8'(n % 256);
                default: begin
                    exp_b[n] = 8'(l);
                    l = ((l << 1) | (((l >> 7) ^ (l >> 5)
                        ^ (l >> 4) ^ (l >> 3)) & 1)) & 255;
                end
            endcase
        end
    endtask

    task automatic apply_reset();
        start_i = 1'b0;
        host.host_dvalid_i = 1'b0;
        host.host_ready_i  = 1'b0;
        host.host_rd_dat_i = 8'h00;
        rst_tk = 1'b1;
        m_idx = 0; m_pat = 0; m_pass = 0; m_err = 0; m_first = 0;
        repeat (2) @(negedge clk_core);
    endtask

    task automatic test_reset();
        apply_reset();
        n_chk++;
        if (host.host_start_o !== 1'b0 || host.host_we_o !== 1'b0
            || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset ctrl: start=%b we=%b busy=%b want 0 0 0",
                     host.host_start_o, host.host_we_o, busy_o);
        end
        n_chk++;
        if (host.host_wr_dat_o !== 8'h55) begin
            n_fail++;
            $display("FAIL reset wr_dat: got %h want 55",
                     host.host_wr_dat_o);
        end
        n_chk++;
        if (host.host_blk_cnt_o !== 8'(BLK)
            || host.host_blk_idx_o !== 16'd0) begin
            n_fail++;
            $display("FAIL reset blk: cnt=%0d idx=%0d want %0d 0",
                     host.host_blk_cnt_o, host.host_blk_idx_o, BLK);
        end
        n_chk++;
        if (pattern_o !== 2'd0 || pass_cnt_o !== 16'd0
            || err_cnt_o !== 16'd0 || first_err_idx_o !== 16'd0) begin
            n_fail++;
            $display("FAIL reset counters: pat=%0d pass=%0d err=%0d first=%0d want 0",
                     pattern_o, pass_cnt_o, err_cnt_o, first_err_idx_o);
        end
        rst_tk = 1'b0;
        @(negedge clk_core);
        n_chk++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL idle busy: got %b want 0", busy_o);
        end
    endtask

    task automatic test_write_entry();
        logic [7:0] first3 [3];
        first3[0] = 8'h55; first3[1] = 8'hAA; first3[2] = 8'h55;
        start_i = 1'b1;
        @(negedge clk_core);
        n_chk++;
        if (busy_o !== 1'b1 || host.host_we_o !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_init: busy=%b we=%b want 1 0",
                     busy_o, host.host_we_o);
        end
        host.host_ready_i = 1'b1;
        @(negedge clk_core);
        host.host_ready_i = 1'b0;
        n_chk++;
        if (host.host_we_o !== 1'b1 || host.host_start_o !== 1'b1
            || host.host_blk_idx_o !== 16'd0) begin
            n_fail++;
            $display("FAIL write entry: we=%b start=%b idx=%0d want 1 1 0",
                     host.host_we_o, host.host_start_o, host.host_blk_idx_o);
        end
        gen_exp(m_pat, m_idx);
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (host.host_wr_dat_o !== first3[k]) begin
                n_fail++;
                $display("FAIL first byte %0d: got %h want %h",
                         k, host.host_wr_dat_o, first3[k]);
            end
            echo_b[k] = host.host_wr_dat_o;
            host.host_dvalid_i = 1'b1;
            @(negedge clk_core);
            host.host_dvalid_i = 1'b0;
        end
    endtask

    task automatic write_phase(input int from);
        int bad;
        bit comb;
        bad = 0;
        comb = 1'($urandom_range(0, 1));
        if (from == 0) begin
            n_chk++;
            if (host.host_we_o !== 1'b1 || host.host_start_o !== 1'b1
                || host.host_blk_idx_o !== 16'(m_idx)) begin
                n_fail++;
                $display("FAIL write entry: we=%b start=%b idx=%0d want 1 1 %0d",
                         host.host_we_o, host.host_start_o,
                         host.host_blk_idx_o, m_idx);
            end
        end
        for (int i = from; i < TOTAL; i++) begin
            if (host.host_wr_dat_o !== exp_b[i]) bad++;
            echo_b[i] = host.host_wr_dat_o;
            host.host_dvalid_i = 1'b1;
            if (comb && i == TOTAL - 1) host.host_ready_i = 1'b1;
            @(negedge clk_core);
            host.host_dvalid_i = 1'b0;
            host.host_ready_i  = 1'b0;
            if (i != TOTAL - 1)
                repeat ($urandom_range(0, 1)) @(negedge clk_core);
        end
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL write data pass %0d: %0d bad bytes, want 0",
                     m_pass, bad);
        end
        if (!comb) begin
            host.host_dvalid_i = 1'b1;
            @(negedge clk_core);
            host.host_dvalid_i = 1'b0;
            n_chk++;
            if (host.host_wr_dat_o !== exp_b[TOTAL-1]) begin
                n_fail++;
                $display("FAIL write hold past last: got %h want %h",
                         host.host_wr_dat_o, exp_b[TOTAL-1]);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk_core);
            host.host_ready_i = 1'b1;
            @(negedge clk_core);
            host.host_ready_i = 1'b0;
        end
    endtask

    task automatic read_phase(input int corrupt, input bit drop,
                              output bit halted);
        bit comb;
        logic [7:0] d;
        halted = 1'b0;
        comb = 1'($urandom_range(0, 1));
        n_chk++;
        if (host.host_we_o !== 1'b0 || host.host_start_o !== 1'b1) begin
            n_fail++;
            $display("FAIL read entry: we=%b start=%b want 0 1",
                     host.host_we_o, host.host_start_o);
        end
        for (int i = 0; i < TOTAL; i++) begin
            if (drop && i == TOTAL / 2) start_i = 1'b0;
            d = echo_b[i];
            if (i == corrupt) d = d ^ 8'hFF;
            if (d != exp_b[i]) begin
                if (m_err == 0) m_first = m_idx;
                m_err++;
            end
            host.host_rd_dat_i = d;
            host.host_dvalid_i = 1'b1;
            if (comb && i == TOTAL - 1) host.host_ready_i = 1'b1;
            @(negedge clk_core);
            host.host_dvalid_i = 1'b0;
            host.host_ready_i  = 1'b0;
            host.host_rd_dat_i = 8'($urandom);
            if (i == corrupt) begin
                n_chk++;
                if (err_cnt_o !== 16'(m_err - 1)) begin
                    n_fail++;
                    $display("FAIL err early: got %0d want %0d",
                             err_cnt_o, m_err - 1);
                end
                @(negedge clk_core);
                n_chk++;
                if (err_cnt_o !== 16'(m_err)
                    || first_err_idx_o !== 16'(m_first)) begin
                    n_fail++;
                    $display("FAIL err count: err=%0d first=%0d want %0d %0d",
                             err_cnt_o, first_err_idx_o, m_err, m_first);
                end
`ifdef EMMC_TG_STOP_ON_ERR_EN
                n_chk++;
                if (busy_o !== 1'b1 || host.host_start_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL halt entry: busy=%b start=%b want 1 0",
                             busy_o, host.host_start_o);
                end
                halted = 1'b1;
                return;
`endif
            end else if (i != TOTAL - 1) begin
                repeat ($urandom_range(0, 1)) @(negedge clk_core);
            end
        end
        if (!comb) begin
            host.host_rd_dat_i = ~exp_b[TOTAL-1];
            host.host_dvalid_i = 1'b1;
            @(negedge clk_core);
            host.host_dvalid_i = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk_core);
            host.host_ready_i = 1'b1;
            @(negedge clk_core);
            host.host_ready_i = 1'b0;
        end
    endtask

    task automatic finish_pass(input bit idle);
        @(negedge clk_core);
        m_pass++;
        m_idx = (m_idx + STRIDE >= LIMIT) ? 0 : m_idx + STRIDE;
        m_pat = (m_pat + 1) % 4;
        n_chk++;
        if (pass_cnt_o !== 16'(m_pass)
            || host.host_blk_idx_o !== 16'(m_idx)
            || pattern_o !== 2'(m_pat)) begin
            n_fail++;
            $display("FAIL advance: pass=%0d idx=%0d pat=%0d want %0d %0d %0d",
                     pass_cnt_o, host.host_blk_idx_o, pattern_o,
                     m_pass, m_idx, m_pat);
        end
        n_chk++;
        if (err_cnt_o !== 16'(m_err)) begin
            n_fail++;
            $display("FAIL pass errors: got %0d want %0d", err_cnt_o, m_err);
        end
        n_chk++;
        if (busy_o !== !idle || host.host_start_o !== !idle) begin
            n_fail++;
            $display("FAIL after pass: busy=%b start=%b want %b %b",
                     busy_o, host.host_start_o, !idle, !idle);
        end
        if (!idle) gen_exp(m_pat, m_idx);
    endtask

    task automatic test_full_pass();
        bit h;
        write_phase(3);
        read_phase(-1, 1'b0, h);
        finish_pass(1'b0);
    endtask

    task automatic test_idx_wrap_and_patterns();
        bit h;
        for (int p = 0; p < 3; p++) begin
            write_phase(0);
            read_phase(-1, 1'b0, h);
            finish_pass(1'b0);
        end
    endtask

    task automatic test_drop_start();
        bit h;
        write_phase(0);
        read_phase(-1, 1'b1, h);
        finish_pass(1'b1);
    endtask

    task automatic test_error();
        bit h;
        apply_reset();
        rst_tk = 1'b0;
        start_i = 1'b1;
        @(negedge clk_core);
        host.host_ready_i = 1'b1;
        @(negedge clk_core);
        host.host_ready_i = 1'b0;
        gen_exp(m_pat, m_idx);
        write_phase(0);
        read_phase(37, 1'b0, h);
        if (h) begin
            host.host_ready_i = 1'b1;
            @(negedge clk_core);
            host.host_ready_i = 1'b0;
            @(negedge clk_core);
            n_chk++;
            if (busy_o !== 1'b1 || host.host_start_o !== 1'b0
                || pass_cnt_o !== 16'd0) begin
                n_fail++;
                $display("FAIL halt hold: busy=%b start=%b pass=%0d want 1 0 0",
                         busy_o, host.host_start_o, pass_cnt_o);
            end
        end else begin
            finish_pass(1'b0);
        end
    endtask

    task automatic test_reset_mid_write();
        for (int k = 0; k < 5; k++) begin
            host.host_dvalid_i = 1'b1;
            @(negedge clk_core);
            host.host_dvalid_i = 1'b0;
        end
        #2 rst_tk = 1'b1;
        #1;
        n_chk++;
        if (host.host_start_o !== 1'b0 || host.host_we_o !== 1'b0
            || busy_o !== 1'b0 || host.host_blk_idx_o !== 16'd0) begin
            n_fail++;
            $display("FAIL async reset ctrl: start=%b we=%b busy=%b idx=%0d",
                     host.host_start_o, host.host_we_o, busy_o,
                     host.host_blk_idx_o);
        end
        n_chk++;
        if (host.host_wr_dat_o !== 8'h55 || pattern_o !== 2'd0
            || pass_cnt_o !== 16'd0 || err_cnt_o !== 16'd0
            || first_err_idx_o !== 16'd0) begin
            n_fail++;
            $display("FAIL async reset data: wr=%h pat=%0d pass=%0d err=%0d first=%0d",
                     host.host_wr_dat_o, pattern_o, pass_cnt_o,
                     err_cnt_o, first_err_idx_o);
        end
        @(negedge clk_core);
        rst_tk = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_entry();
        test_full_pass();
        test_idx_wrap_and_patterns();
        test_drop_start();
        test_error();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
